// File: rtl/conv_pkg.sv
// Shared types, widths and the requantization helper used by conv output and requant stages.
package conv_pkg;

  localparam int unsigned ACC_W = 32;
  localparam int unsigned IO_W  = 16;
  localparam int unsigned X_W   = 10;
  localparam int unsigned Y_W   = 10;
  localparam int unsigned CH_W  = 6;

  typedef logic [X_W-1:0]  x_t;
  typedef logic [Y_W-1:0]  y_t;
  typedef logic [CH_W-1:0] ch_t;

  typedef struct packed {
    logic signed [ACC_W:0] value;
    logic                  sat;
  } quant_t;

  // Round-half-up shift, optional ReLU, then clamp to a signed io_w-bit range.
  // acc must already be sign-extended to ACC_W+1 bits; io_w may be at most ACC_W.
  function automatic quant_t quantize(input logic signed [ACC_W:0] acc,
                                      input int unsigned           shift,
                                      input logic                  relu,
                                      input int unsigned           io_w);
    logic signed [ACC_W:0] t;
    logic signed [ACC_W:0] bias;
    logic signed [ACC_W:0] hi;
    logic signed [ACC_W:0] lo;
    quant_t                q;
    t    = acc;
    bias = '0;
    if (shift != 0) begin
      bias = (ACC_W+1)'(1) << (shift - 1);
      t    = (acc + bias) >>> shift;
    end
    if (relu && t[ACC_W]) t = '0;
    hi    = (ACC_W+1)'((64'd1 << (io_w - 1)) - 64'd1);
    lo    = ~hi;
    q.sat = 1'b0;
    if (t > hi) begin
      t     = hi;
      q.sat = 1'b1;
    end else if (t < lo) begin
      t     = lo;
      q.sat = 1'b1;
    end
    q.value = t;
    return q;
  endfunction

endpackage

// File: rtl/conv_output_drain_sync_fifo.sv
// First-word-fall-through FIFO; head is valid whenever empty is low.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  // Extra pointer MSB separates the full and empty cases.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/conv_output_drain.sv
// Quantizes finished accumulations, buffers them with coordinates and drains them to the host.
module conv_output_drain
  import conv_pkg::*;
#(
  parameter int unsigned ACCUMULATION_WIDTH = ACC_W,
  parameter int unsigned IO_DATA_WIDTH      = IO_W,
  parameter int unsigned OUTPUT_SHIFT       = 0,
  parameter int unsigned RELU               = 0,
  parameter int unsigned FIFO_DEPTH         = 4,
  parameter int unsigned FEATURE_MAP_WIDTH  = 1024,
  parameter int unsigned FEATURE_MAP_HEIGHT = 1024,
  parameter int unsigned OUTPUT_NB_CHANNELS = 64,
  localparam int unsigned XB    = $clog2(FEATURE_MAP_WIDTH),
  localparam int unsigned YB    = $clog2(FEATURE_MAP_HEIGHT),
  localparam int unsigned CB    = $clog2(OUTPUT_NB_CHANNELS),
  localparam int unsigned MAP_SIZE = FEATURE_MAP_WIDTH * FEATURE_MAP_HEIGHT * OUTPUT_NB_CHANNELS,
  localparam int unsigned CNT_W = $clog2(MAP_SIZE + 1)
) (
  input  logic                          clk,
  input  logic                          arst_n_in,
  input  logic [ACCUMULATION_WIDTH-1:0] in_data,
  input  logic [XB-1:0]                 in_x,
  input  logic [YB-1:0]                 in_y,
  input  logic [CB-1:0]                 in_ch,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [IO_DATA_WIDTH-1:0]      out_data,
  output logic [XB-1:0]                 out_x,
  output logic [YB-1:0]                 out_y,
  output logic [CB-1:0]                 out_ch,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          sat_flag,
  input  logic                          clear,
  output logic [CNT_W-1:0]              out_count,
  output logic                          done
);

  localparam int unsigned ENTRY_W = IO_DATA_WIDTH + XB + YB + CB;

  logic                     ready_en;
  logic                     s1_valid;
  logic [IO_DATA_WIDTH-1:0] s1_data;
  logic [XB-1:0]            s1_x;
  logic [YB-1:0]            s1_y;
  logic [CB-1:0]            s1_ch;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [ENTRY_W-1:0]       fifo_head;
  logic                     accept;
  logic                     push;
  logic                     pop;
  logic signed [ACC_W:0]    acc_ext;
  quant_t                   q_c;

  // Quantize on the input side so S1 holds the final IO-width value.
  always_comb begin
    acc_ext = (ACC_W+1)'(signed'(in_data));
    q_c     = quantize(acc_ext, OUTPUT_SHIFT, RELU != 0, IO_DATA_WIDTH);
  end

  assign in_ready  = ready_en && (!s1_valid || !fifo_full);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  // A pop frees the slot S1 writes into, so S1 can drain into a full FIFO.
  assign push      = s1_valid && (!fifo_full || pop);
  assign out_valid = !fifo_empty;
  assign {out_data, out_x, out_y, out_ch} = fifo_head;

  // in_ready stays low for the first cycle after reset release.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) ready_en <= 1'b0;
    else            ready_en <= 1'b1;
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_ch    <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_data  <= q_c.value[IO_DATA_WIDTH-1:0];
      s1_x     <= in_x;
      s1_y     <= in_y;
      s1_ch    <= in_ch;
    end else if (push) begin
      s1_valid <= 1'b0;
    end
  end

  // Sticky saturation: a new event outranks a coincident clear.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in)             sat_flag <= 1'b0;
    else if (accept && q_c.sat) sat_flag <= 1'b1;
    else if (clear)             sat_flag <= 1'b0;
  end

  // Drain counter wraps on the last output of a map and flags it with done.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      out_count <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (clear) begin
        out_count <= '0;
      end else if (pop) begin
        if (out_count == CNT_W'(MAP_SIZE - 1)) begin
          out_count <= '0;
          done      <= 1'b1;
        end else begin
          out_count <= out_count + CNT_W'(1);
        end
      end
    end
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (arst_n_in),
    .push  (push),
    .pop   (pop),
    .din   ({s1_data, s1_x, s1_y, s1_ch}),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

endmodule

// File: tb/tb_conv_output_drain.sv
// Directed bench for conv_output_drain: passthrough, rounding, ReLU, backpressure, count/done, reset.
module tb_conv_output_drain;

  logic clk = 1'b0;
  logic arst_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  // a: passthrough, default map
  logic [31:0] a_data;
  logic [9:0]  a_x, a_y, a_out_x, a_out_y;
  logic [5:0]  a_ch, a_out_ch;
  logic        a_valid, a_in_ready, a_out_valid, a_out_ready, a_sat, a_clear, a_done;
  logic [15:0] a_out_data;
  logic [26:0] a_count;
  // b: shift 4, 2x2x2 map
  logic [31:0] b_data;
  logic        b_x, b_y, b_ch, b_out_x, b_out_y, b_out_ch;
  logic        b_valid, b_in_ready, b_out_valid, b_out_ready, b_sat, b_clear, b_done;
  logic [15:0] b_out_data;
  logic [3:0]  b_count;
  // c: ReLU
  logic [31:0] c_data;
  logic [9:0]  c_x, c_y, c_out_x, c_out_y;
  logic [5:0]  c_ch, c_out_ch;
  logic        c_valid, c_in_ready, c_out_valid, c_out_ready, c_sat, c_clear, c_done;
  logic [15:0] c_out_data;
  logic [26:0] c_count;

  conv_output_drain u_a (
    .clk(clk), .arst_n_in(arst_n), .in_data(a_data), .in_x(a_x), .in_y(a_y), .in_ch(a_ch),
    .in_valid(a_valid), .in_ready(a_in_ready), .out_data(a_out_data), .out_x(a_out_x),
    .out_y(a_out_y), .out_ch(a_out_ch), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .sat_flag(a_sat), .clear(a_clear), .out_count(a_count), .done(a_done)
  );

  conv_output_drain #(
    .OUTPUT_SHIFT(4), .FEATURE_MAP_WIDTH(2), .FEATURE_MAP_HEIGHT(2), .OUTPUT_NB_CHANNELS(2)
  ) u_b (
    .clk(clk), .arst_n_in(arst_n), .in_data(b_data), .in_x(b_x), .in_y(b_y), .in_ch(b_ch),
    .in_valid(b_valid), .in_ready(b_in_ready), .out_data(b_out_data), .out_x(b_out_x),
    .out_y(b_out_y), .out_ch(b_out_ch), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .sat_flag(b_sat), .clear(b_clear), .out_count(b_count), .done(b_done)
  );

  conv_output_drain #(.RELU(1)) u_c (
    .clk(clk), .arst_n_in(arst_n), .in_data(c_data), .in_x(c_x), .in_y(c_y), .in_ch(c_ch),
    .in_valid(c_valid), .in_ready(c_in_ready), .out_data(c_out_data), .out_x(c_out_x),
    .out_y(c_out_y), .out_ch(c_out_ch), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .sat_flag(c_sat), .clear(c_clear), .out_count(c_count), .done(c_done)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    a_data = '0; a_x = '0; a_y = '0; a_ch = '0; a_valid = 0; a_out_ready = 0; a_clear = 0;
    b_data = '0; b_x = '0; b_y = '0; b_ch = '0; b_valid = 0; b_out_ready = 0; b_clear = 0;
    c_data = '0; c_x = '0; c_y = '0; c_ch = '0; c_valid = 0; c_out_ready = 0; c_clear = 0;
    tick(); tick();
    checks++; if (a_in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", a_in_ready); end
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", a_out_valid); end
    checks++; if (a_count !== 27'd0 || a_sat !== 1'b0 || a_done !== 1'b0 || a_out_data !== 16'd0) begin
      failures++; $display("FAIL reset_state count=%0d sat=%b done=%b data=%0d exp all 0", a_count, a_sat, a_done, a_out_data);
    end
    arst_n = 1'b1;
    #1;
    checks++; if (a_in_ready !== 1'b0) begin failures++; $display("FAIL release_in_ready_early got=%b exp=0", a_in_ready); end
    tick();
    checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready got=%b exp=1", a_in_ready); end
  endtask

  task automatic test_passthrough();
    a_out_ready = 1'b1;
    a_data = 32'd1234; a_x = 10'd3; a_y = 10'd5; a_ch = 6'd7; a_valid = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0;
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL pass_latency_early got=%b exp=0", a_out_valid); end
    @(posedge clk); #1;
    checks++; if (a_out_valid !== 1'b1 || a_out_data !== 16'd1234) begin
      failures++; $display("FAIL pass_data valid=%b data=%0d exp valid=1 data=1234", a_out_valid, a_out_data);
    end
    checks++; if (a_out_x !== 10'd3 || a_out_y !== 10'd5 || a_out_ch !== 6'd7) begin
      failures++; $display("FAIL pass_coord got=(%0d,%0d,%0d) exp=(3,5,7)", a_out_x, a_out_y, a_out_ch);
    end
    @(negedge clk);
    checks++; if (a_sat !== 1'b0) begin failures++; $display("FAIL pass_sat_clean got=%b exp=0", a_sat); end
    a_data = 32'(-40000); a_valid = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (a_out_data !== 16'h8000) begin failures++; $display("FAIL pass_sat_neg got=%0d exp=-32768", $signed(a_out_data)); end
    checks++; if (a_sat !== 1'b1) begin failures++; $display("FAIL pass_sat_flag got=%b exp=1", a_sat); end
    @(negedge clk);
  endtask

  task automatic test_rounding();
    int   in_r  [4] = '{24, 23, -24, -25};
    int   exp_r [4] = '{2, 1, -1, -2};
    int   fed = 0;
    int   got = 0;
    logic take;
    b_out_ready = 1'b1;
    for (int c = 0; c < 20 && got < 4; c++) begin
      b_valid = (fed < 4);
      b_data  = 32'(in_r[(fed < 4) ? fed : 0]);
      take    = b_valid && b_in_ready;
      if (b_out_valid) begin
        checks++; if (b_out_data !== 16'(exp_r[got])) begin
          failures++; $display("FAIL round_%0d got=%0d exp=%0d", got, $signed(b_out_data), exp_r[got]);
        end
        got++;
      end
      tick();
      if (take) fed++;
    end
    b_valid = 1'b0;
    checks++; if (got != 4) begin failures++; $display("FAIL round_drained got=%0d exp=4", got); end
    checks++; if (b_count !== 4'd4) begin failures++; $display("FAIL round_count got=%0d exp=4", b_count); end
    b_clear = 1'b1;
    tick();
    b_clear = 1'b0;
    checks++; if (b_count !== 4'd0) begin failures++; $display("FAIL clear_count got=%0d exp=0", b_count); end
  endtask

  task automatic test_relu();
    c_out_ready = 1'b1;
    c_data = 32'(-5); c_valid = 1'b1;
    tick();
    c_valid = 1'b0;
    tick();
    checks++; if (c_out_valid !== 1'b1 || c_out_data !== 16'd0) begin
      failures++; $display("FAIL relu_neg valid=%b data=%0d exp valid=1 data=0", c_out_valid, $signed(c_out_data));
    end
    checks++; if (c_sat !== 1'b0) begin failures++; $display("FAIL relu_no_sat got=%b exp=0", c_sat); end
    c_data = 32'd70000; c_valid = 1'b1;
    tick();
    c_valid = 1'b0;
    tick();
    checks++; if (c_out_data !== 16'd32767) begin failures++; $display("FAIL relu_pos_sat got=%0d exp=32767", $signed(c_out_data)); end
    checks++; if (c_sat !== 1'b1) begin failures++; $display("FAIL relu_sat_flag got=%b exp=1", c_sat); end
    c_clear = 1'b1;
    tick();
    checks++; if (c_sat !== 1'b0) begin failures++; $display("FAIL relu_clear got=%b exp=0", c_sat); end
    c_data = 32'd70000; c_valid = 1'b1;
    tick();
    c_valid = 1'b0; c_clear = 1'b0;
    checks++; if (c_sat !== 1'b1) begin failures++; $display("FAIL sat_beats_clear got=%b exp=1", c_sat); end
    tick(); tick();
  endtask

  task automatic test_backpressure();
    int   acc = 0;
    int   got = 0;
    int   first_c = -1;
    int   last_c = -1;
    logic take;
    a_out_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      a_valid = 1'b1; a_data = 32'(100 + acc); a_x = 10'(acc);
      take = a_in_ready;
      tick();
      if (take) acc++;
    end
    checks++; if (acc != 5) begin failures++; $display("FAIL bp_accepts got=%0d exp=5", acc); end
    checks++; if (a_in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b exp=0", a_in_ready); end
    a_out_ready = 1'b1;
    for (int c = 0; c < 40 && got < 10; c++) begin
      a_valid = (acc < 10); a_data = 32'(100 + acc); a_x = 10'(acc);
      take = a_valid && a_in_ready;
      if (a_out_valid) begin
        checks++; if (a_out_data !== 16'(100 + got) || a_out_x !== 10'(got)) begin
          failures++; $display("FAIL bp_order_%0d got=%0d/x%0d exp=%0d/x%0d", got, a_out_data, a_out_x, 100 + got, got);
        end
        if (first_c < 0) first_c = c;
        last_c = c;
        got++;
      end
      tick();
      if (take) acc++;
    end
    a_valid = 1'b0;
    checks++; if (got != 10) begin failures++; $display("FAIL bp_drained got=%0d exp=10", got); end
    checks++; if (last_c - first_c != 9) begin failures++; $display("FAIL bp_rate span=%0d exp=9", last_c - first_c); end
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL bp_empty got=%b exp=0", a_out_valid); end
  endtask

  task automatic test_count_done();
    int   fed = 0;
    int   pops = 0;
    int   done_seen = 0;
    int   done_at = -1;
    logic mid_done = 1'b0;
    logic take;
    logic pop;
    b_out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (b_done) begin done_seen++; done_at = pops; end
      if (pops == 4 && !mid_done) begin
        mid_done = 1'b1;
        checks++; if (b_count !== 4'd4) begin failures++; $display("FAIL count_mid got=%0d exp=4", b_count); end
      end
      b_valid = (fed < 8); b_data = 32'(16 * fed); b_x = 1'(fed); b_y = 1'(fed >> 1); b_ch = 1'(fed >> 2);
      take = b_valid && b_in_ready;
      pop  = b_out_valid;
      tick();
      if (take) fed++;
      if (pop) pops++;
    end
    b_valid = 1'b0;
    checks++; if (done_seen != 1 || done_at != 8) begin
      failures++; $display("FAIL done_pulse seen=%0d at_pop=%0d exp seen=1 at_pop=8", done_seen, done_at);
    end
    checks++; if (b_count !== 4'd0) begin failures++; $display("FAIL count_wrap got=%0d exp=0", b_count); end
  endtask

  task automatic test_clear_with_pop();
    int   fed = 0;
    int   pops = 0;
    logic take;
    logic pop;
    b_out_ready = 1'b1;
    for (int c = 0; c < 30 && pops < 7; c++) begin
      b_valid = (fed < 7); b_data = 32'(fed);
      take = b_valid && b_in_ready;
      pop  = b_out_valid;
      tick();
      if (take) fed++;
      if (pop) pops++;
    end
    b_valid = 1'b0;
    checks++; if (b_count !== 4'd7) begin failures++; $display("FAIL clr_pre_count got=%0d exp=7", b_count); end
    b_out_ready = 1'b0;
    b_valid = 1'b1; b_data = 32'd99;
    tick();
    b_valid = 1'b0;
    tick();
    checks++; if (b_out_valid !== 1'b1) begin failures++; $display("FAIL clr_queued got=%b exp=1", b_out_valid); end
    b_clear = 1'b1; b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_clear = 1'b0;
    checks++; if (b_count !== 4'd0 || b_done !== 1'b0) begin
      failures++; $display("FAIL clr_with_pop count=%0d done=%b exp count=0 done=0", b_count, b_done);
    end
    tick();
    checks++; if (b_done !== 1'b0 || b_out_valid !== 1'b0) begin
      failures++; $display("FAIL clr_after done=%b valid=%b exp 0/0", b_done, b_out_valid);
    end
  endtask

  task automatic test_reset_mid();
    a_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_valid = 1'b1; a_data = 32'(50 + i);
      tick();
    end
    a_valid = 1'b0;
    tick();
    checks++; if (a_out_valid !== 1'b1 || a_count !== 27'd12 || a_sat !== 1'b1) begin
      failures++; $display("FAIL pre_reset valid=%b count=%0d sat=%b exp 1/12/1", a_out_valid, a_count, a_sat);
    end
    #2 arst_n = 1'b0;
    #1;
    checks++; if (a_out_valid !== 1'b0 || a_out_data !== 16'd0 || a_out_x !== 10'd0) begin
      failures++; $display("FAIL mid_reset_out valid=%b data=%0d x=%0d exp 0/0/0", a_out_valid, a_out_data, a_out_x);
    end
    checks++; if (a_count !== 27'd0 || a_sat !== 1'b0 || a_in_ready !== 1'b0) begin
      failures++; $display("FAIL mid_reset_state count=%0d sat=%b rdy=%b exp 0/0/0", a_count, a_sat, a_in_ready);
    end
    @(negedge clk);
    arst_n = 1'b1;
    tick();
    a_out_ready = 1'b1;
    a_data = 32'd7; a_valid = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (a_out_valid !== 1'b1 || a_out_data !== 16'd7) begin
      failures++; $display("FAIL resume valid=%b data=%0d exp valid=1 data=7", a_out_valid, a_out_data);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_passthrough();
    test_rounding();
    test_relu();
    test_backpressure();
    test_count_done();
    test_clear_with_pop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
